// File: rtl/d_phy_transmitter.sv
// d_phy_transmitter
// Serialises a byte stream into MIPI D-PHY style HS bursts as DDR bit-pairs.
// A burst is HS-ZERO, the 0xB8 sync byte, the payload bytes, then HS-TRAIL.
// The lane then returns to IDLE.
//
// Ports
//   clock      : single clock; one bit-pair is produced per rising edge
//   reset      : synchronous, active-high reset
//   in_data    : payload byte, sampled only when accepted
//   in_valid   : in_data/in_last are valid
//   in_last    : the current byte ends the burst
//   in_ready   : byte accepted when in_valid && in_ready at a rising edge
//   data_h     : earlier bit of the pair (rising-edge slot of the DDR register)
//   data_l     : later bit of the pair (falling-edge slot)
//   hs_active  : lane is driven in HS mode; low means the lane is released
//   busy       : high in every state except IDLE
module d_phy_transmitter #(
  parameter int unsigned ZERO_CYCLES  = 6,
  parameter int unsigned TRAIL_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       data_h,
  output logic       data_l,
  output logic       hs_active,
  output logic       busy
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned PAIR_W   = 2;
  localparam logic [7:0]  SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PAIR_W-1:0]  r_pair;
  logic [7:0]         r_byte;
  logic               r_last;

  logic               w_pair3;
  logic [PAIR_W-1:0]  w_next_pair;
  logic               w_zero_done;
  logic               w_trail_done;

  // Pair k of a byte: earlier bit byte[2k], later bit byte[2k+1] (LSB first).
  function automatic logic [1:0] pair_bits(input logic [7:0] b, input logic [PAIR_W-1:0] k);
    pair_bits = {b[{k, 1'b0}], b[{k, 1'b1}]};
  endfunction

  assign w_pair3      = (r_pair == 2'd3);
  assign w_next_pair  = r_pair + 2'd1;
  assign w_zero_done  = (r_cnt == CNT_W'(ZERO_CYCLES - 1));
  assign w_trail_done = (r_cnt == CNT_W'(TRAIL_CYCLES - 1));

  // A new byte can follow only the last sync pair or a non-final payload byte.
  assign in_ready = w_pair3 &&
                    ((r_state == ST_SYNC) || ((r_state == ST_DATA) && !r_last));
  assign busy     = (r_state != ST_IDLE);

  // Burst sequencer; line outputs are loaded together with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pair    <= '0;
      r_byte    <= '0;
      r_last    <= 1'b0;
      data_h    <= 1'b0;
      data_l    <= 1'b0;
      hs_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state   <= ST_HS_ZERO;
            r_cnt     <= '0;
            hs_active <= 1'b1;
            data_h    <= 1'b0;
            data_l    <= 1'b0;
          end
        end

        ST_HS_ZERO: begin
          if (w_zero_done) begin
            r_state          <= ST_SYNC;
            r_cnt            <= '0;
            r_pair           <= '0;
            {data_h, data_l} <= pair_bits(SYNC_BYTE, 2'd0);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_SYNC: begin
          if (!w_pair3) begin
            r_pair           <= w_next_pair;
            {data_h, data_l} <= pair_bits(SYNC_BYTE, w_next_pair);
          end else if (in_valid) begin
            r_state          <= ST_DATA;
            r_pair           <= '0;
            r_byte           <= in_data;
            r_last           <= in_last;
            {data_h, data_l} <= pair_bits(in_data, 2'd0);
          end else begin
            // Underflow straight after sync: last bit sent was sync bit 7.
            r_state <= ST_TRAIL;
            r_cnt   <= '0;
            r_pair  <= '0;
            data_h  <= ~SYNC_BYTE[7];
            data_l  <= ~SYNC_BYTE[7];
          end
        end

        ST_DATA: begin
          if (!w_pair3) begin
            r_pair           <= w_next_pair;
            {data_h, data_l} <= pair_bits(r_byte, w_next_pair);
          end else if (!r_last && in_valid) begin
            r_pair           <= '0;
            r_byte           <= in_data;
            r_last           <= in_last;
            {data_h, data_l} <= pair_bits(in_data, 2'd0);
          end else begin
            // Final byte done, or underflow: trail with the inverse of bit 7.
            r_state <= ST_TRAIL;
            r_cnt   <= '0;
            r_pair  <= '0;
            r_last  <= 1'b0;
            data_h  <= ~r_byte[7];
            data_l  <= ~r_byte[7];
          end
        end

        ST_TRAIL: begin
          if (w_trail_done) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            hs_active <= 1'b0;
            data_h    <= 1'b0;
            data_l    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_pair    <= '0;
          hs_active <= 1'b0;
          data_h    <= 1'b0;
          data_l    <= 1'b0;
        end
      endcase
    end
  end

endmodule
